up_down_counter_param: RTL and testbench

UP_DOWN_COUNTER_PARAM -- requirements
Module: up_down_counter_param

---
 rtl/up_down_counter_param_if.sv | 24 ++
 rtl/up_down_counter_param.sv | 75 +++++++
 tb/tb_up_down_counter_param.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_param_if.sv
// rtl/up_down_counter_param_if.sv - control and status bundle for up_down_counter_param
interface up_down_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic             updown;
  logic [WIDTH-1:0] data_in;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, load, updown, data_in, clr_flag,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  en, load, updown, data_in, clr_flag,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - modulo up/down counter with load, wrap pulse and sticky ovf (UDC_SATURATE_EN selects saturate mode)
module up_down_counter_param #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  up_down_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             ovf_q;
  logic             at_top;
  logic             at_bot;
  logic             boundary_step;
  logic [WIDTH-1:0] load_val;

  // Boundary detection and load clamping shared by the register and tc logic
  always_comb begin
    at_top        = (count_q == MAX_VAL);
    at_bot        = (count_q == '0);
    boundary_step = !bus.load && bus.en && (bus.updown ? at_top : at_bot);
    load_val      = (bus.data_in > MAX_VAL) ? MAX_VAL : bus.data_in;
  end

  // Count, wrap pulse and sticky overflow; a boundary step beats clr_flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wrap_q <= boundary_step;
      if (boundary_step) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_flag) begin
        ovf_q <= 1'b0;
      end
      if (bus.load) begin
        count_q <= load_val;
      end else if (bus.en) begin
        if (bus.updown) begin
          if (at_top) begin
`ifdef UDC_SATURATE_EN
            count_q <= MAX_VAL;
`else
            count_q <= '0;
`endif
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end else begin
          if (at_bot) begin
`ifdef UDC_SATURATE_EN
            count_q <= '0;
`else
            count_q <= MAX_VAL;
`endif
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = bus.updown ? at_top : at_bot;
  assign bus.wrap  = wrap_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - self-checking bench for up_down_counter_param (WIDTH=8, MODULUS=200)
module tb_up_down_counter_param;

  localparam int WIDTH   = 8;
  localparam int MODULUS = 200;

  typedef struct {
    logic       load;
    logic       en;
    logic       updown;
    logic [7:0] data_in;
    logic       clr_flag;
    logic [7:0] exp_count;
    logic       exp_tc;
    logic       exp_wrap;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[$];

  up_down_counter_param_if #(.WIDTH(WIDTH)) bus ();

  up_down_counter_param #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [7:0] c, input logic t,
                               input logic w, input logic o);
    check({name, ".count"}, 32'(bus.count), 32'(c));
    check({name, ".tc"},    32'(bus.tc),    32'(t));
    check({name, ".wrap"},  32'(bus.wrap),  32'(w));
    check({name, ".ovf"},   32'(bus.ovf),   32'(o));
  endtask

  // Drive one cycle of inputs on the falling edge, queue the expectation,
  // then compare just after the rising edge.
  task automatic step(input string name, input logic ld, input logic e, input logic ud,
                      input logic [7:0] din, input logic clr, input logic [7:0] c,
                      input logic t, input logic w, input logic o);
    exp_t x;
    @(negedge clk);
    bus.load     = ld;
    bus.en       = e;
    bus.updown   = ud;
    bus.data_in  = din;
    bus.clr_flag = clr;
    x.name = name; x.count = c; x.tc = t; x.wrap = w; x.ovf = o;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=empty_queue required=entry", name);
    end else begin
      x = sb.pop_front();
      check_outputs(x.name, x.count, x.tc, x.wrap, x.ovf);
    end
  endtask

  function automatic vec_t mk(logic ld, logic e, logic ud, logic [7:0] din, logic clr,
                              logic [7:0] c, logic t, logic w, logic o);
    vec_t v;
    v.load = ld; v.en = e; v.updown = ud; v.data_in = din; v.clr_flag = clr;
    v.exp_count = c; v.exp_tc = t; v.exp_wrap = w; v.exp_ovf = o;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.en       = 1'b0;
    bus.updown   = 1'b1;
    bus.data_in  = '0;
    bus.clr_flag = 1'b0;

    // Vector table: ld en ud data clr | count tc wrap ovf
    vecs.push_back(mk(1, 0, 1, 198, 0, 198, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,   0, 0, 199, 1, 0, 0));
`ifdef UDC_SATURATE_EN
    vecs.push_back(mk(0, 1, 1,   0, 0, 199, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1,   0, 0, 199, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1,   0, 1, 199, 1, 0, 0));
`else
    vecs.push_back(mk(0, 1, 1,   0, 0,   0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1,   0, 0,   1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 1,   1, 0, 0, 0));
`endif
    vecs.push_back(mk(1, 0, 1, 250, 0, 199, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,   0, 0,   0, 1, 0, 0));
`ifdef UDC_SATURATE_EN
    vecs.push_back(mk(0, 1, 0,   0, 0,   0, 1, 1, 1));
`else
    vecs.push_back(mk(0, 1, 0,   0, 0, 199, 0, 1, 1));
`endif
    vecs.push_back(mk(1, 1, 1, 100, 0, 100, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1,   0, 0, 100, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0,   0, 0,  99, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 199, 0, 199, 1, 0, 1));
`ifdef UDC_SATURATE_EN
    vecs.push_back(mk(0, 1, 1,   0, 1, 199, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1,   0, 1, 199, 1, 0, 0));
`else
    vecs.push_back(mk(0, 1, 1,   0, 1,   0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1,   0, 1,   0, 0, 0, 0));
`endif
    vecs.push_back(mk(1, 0, 0,   5, 0,   5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,   0, 0,   6, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0,   5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0,   5, 0, 0, 0));

    // Reset state while rst is held low across an edge
    @(posedge clk);
    #1;
    check_outputs("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].load, vecs[i].en, vecs[i].updown,
           vecs[i].data_in, vecs[i].clr_flag, vecs[i].exp_count, vecs[i].exp_tc,
           vecs[i].exp_wrap, vecs[i].exp_ovf);
    end

    // Async reset mid-count at 57 with ovf set and an increment pending
    step("pre57_load", 1, 0, 1, 199, 0, 199, 1, 0, 0);
`ifdef UDC_SATURATE_EN
    step("pre57_bnd", 0, 1, 1, 0, 0, 199, 1, 1, 1);
`else
    step("pre57_bnd", 0, 1, 1, 0, 0, 0, 0, 1, 1);
`endif
    step("load57", 1, 0, 1, 57, 0, 57, 0, 0, 1);
    @(negedge clk);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst57", 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset while the wrap pulse is high, then a pending load on release
    @(negedge clk);
    rst = 1'b1;
    step("bnd_load", 1, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef UDC_SATURATE_EN
    step("bnd_down", 0, 1, 0, 0, 0, 0, 1, 1, 1);
`else
    step("bnd_down", 0, 1, 0, 0, 0, 199, 0, 1, 1);
`endif
    @(negedge clk);
    bus.load    = 1'b1;
    bus.en      = 1'b0;
    bus.data_in = 8'd10;
    #1;
    rst = 1'b0;
    #1;
    check_outputs("async_rst_wrap", 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_hold_load", 8'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("first_edge_load", 8'd10, 1'b0, 1'b0, 1'b0);
    step("after_rst_dec", 0, 1, 0, 0, 0, 9, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
